// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a synchronous instruction memory,
// buffers responses in a 2-entry FIFO and presents them to decode with a
// valid/ready handshake. Redirects flush everything in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  count_next;

  // Occupancy seen after this cycle's pop; the in-flight response already
  // owns a slot, so issuing is only allowed while fewer than two are held.
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = ~redirect_valid & (occupancy < 3'd2);
  assign imem_pc   = fetch_pc;

  // Push and pop together leave the count unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // Fetch address and in-flight tracking; a redirect wins over issuing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC_ALIGNED;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  // FIFO pointers and count; a redirect discards every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  // One storage slot per entry, written when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_pc[gi]    <= '0;
          buf_instr[gi] <= '0;
        end else if (push && (wr_ptr == 1'(gi))) begin
          buf_pc[gi]    <= inflight_pc;
          buf_instr[gi] <= imem_instr;
        end
      end
    end
  endgenerate

  // Head of the FIFO only; memory data never bypasses to the outputs.
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : 32'd0;
  assign out_instr = out_valid ? buf_instr[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic checked
// against a stream-level model (issued-minus-consumed bookkeeping and the
// expected in-order pc sequence from the last flush point).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic [31:0] imem_pc2;
  logic [31:0] imem_instr2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_pc(out_pc2), .out_instr(out_instr2)
  );

  // Synchronous memories: word at address a is a + 0x100.
  always @(posedge clk) begin
    imem_instr  <= imem_pc + 32'h100;
    imem_instr2 <= imem_pc2 + 32'h100;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Stream-level model state.
  logic [31:0] exp_fetch;   // address the memory should see
  logic [31:0] head_pc;     // oldest issued-but-unconsumed address
  int          outst;       // issued since flush minus consumed
  int          last_issue;  // whether the previous cycle issued
  int          step_idx;
  int          first_valid_step;

  task automatic model_reset(input logic [31:0] rpc);
    exp_fetch        = rpc;
    head_pc          = rpc;
    outst            = 0;
    last_issue       = 0;
    step_idx         = 0;
    first_valid_step = -1;
  endtask

  // One cycle: check what the DUT presents, drive inputs, advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp);
    int  fifo_cnt;
    logic exp_valid;
    logic pop;
    int  issue;
    @(negedge clk);
    fifo_cnt  = outst - last_issue;
    exp_valid = (fifo_cnt != 0);
    check("imem_pc", imem_pc, exp_fetch);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("out_pc", out_pc, head_pc);
      check("out_instr", out_instr, head_pc + 32'h100);
    end
    if (out_valid && first_valid_step < 0) first_valid_step = step_idx;
    $display("t=%0t step=%0d ready=%0d redir=%0d pc=%08h valid=%0d out_pc=%08h",
             $time, step_idx, r, rv, imem_pc, out_valid, out_pc);
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    pop = exp_valid && r;
    if (pop) head_pc = head_pc + 32'd4;
    if (rv) begin
      exp_fetch  = {rp[31:2], 2'b00};
      head_pc    = {rp[31:2], 2'b00};
      outst      = 0;
      last_issue = 0;
    end else begin
      issue      = ((outst - (pop ? 1 : 0)) < 2) ? 1 : 0;
      outst      = outst - (pop ? 1 : 0) + issue;
      last_issue = issue;
      if (issue != 0) exp_fetch = exp_fetch + 32'd4;
    end
    step_idx++;
  endtask

  // Assert reset between edges, confirm outputs clear at once, then release
  // just after a rising edge so the next step models the first live cycle.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_imem_pc", imem_pc, 32'd0);
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_imem_pc", imem_pc, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset(32'h0);
    $display("t=%0t reset released", $time);
  endtask

  logic [31:0] pcs2 [3];
  logic [31:0] ins2 [3];
  int          n2 = 0;

  always @(negedge clk) begin
    if (!rst && out_valid2 && n2 < 3) begin
      pcs2[n2] = out_pc2;
      ins2[n2] = out_instr2;
      n2++;
    end
  end

  initial begin
    model_reset(32'h0);
    do_reset();

    // Stream from reset with decode always ready; first output two cycles in.
    repeat (6) step(1'b1, 1'b0, 32'd0);
    check("first_valid_latency", first_valid_step, 32'd2);

    // Stall decode for five cycles, then resume.
    repeat (5) step(1'b0, 1'b0, 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'd0);

    // Fill the FIFO, then redirect to an unaligned target.
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0043);
    repeat (4) step(1'b1, 1'b0, 32'd0);

    // Redirect while the head is being consumed.
    step(1'b1, 1'b1, 32'h0000_0010);
    repeat (3) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (4) step(1'b1, 1'b0, 32'd0);

    // Reset mid-stream with the FIFO full.
    repeat (4) step(1'b0, 1'b0, 32'd0);
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'd0);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0),
             $urandom());
      end
    end

    // Second instance starts near the top of the address space and wraps.
    check("wrap_count", n2, 32'd3);
    if (n2 == 3) begin
      check("wrap_pc0", pcs2[0], 32'hFFFF_FFF8);
      check("wrap_pc1", pcs2[1], 32'hFFFF_FFFC);
      check("wrap_pc2", pcs2[2], 32'h0000_0000);
      check("wrap_instr0", ins2[0], 32'h0000_00F8);
      check("wrap_instr2", ins2[2], 32'h0000_0100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
